// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - shared types and constants for the instruction-memory controller
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 16;

endpackage

// File: rtl/imem_ctrl_byte_packer.sv
// rtl/imem_ctrl_byte_packer.sv - packs a byte stream little-endian into 32-bit words
module byte_packer
    import imem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic        word_full,
    output logic [31:0] word
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;

    // The lane being filled is the last one: this push completes the word.
    assign word_full = push && (cnt_q == 2'(WORD_BYTES - 1));
    assign word      = word_q;

    // Byte lane register and lane counter; first byte of a word lands in [7:0].
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (push) begin
            word_q[{cnt_q, 3'b000} +: 8] <= data;
            cnt_q                        <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - fetch pass-through and byte-stream program loader for instruction memory
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int BYTES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic [LEN_W-1:0] load_len,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    input  logic [31:0]      fetch_a,
    output logic             core_stall,
    output logic             load_busy,
    output logic             load_done,
    output logic             load_err,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd
);

    localparam int               WORDS   = BYTES / WORD_BYTES;
    localparam logic [LEN_W-1:0] WORDS_L = LEN_W'(WORDS);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] word_idx_q, word_idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    logic             pk_clear;
    logic             pk_push;
    logic             pk_full;
    logic [31:0]      pk_word;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear),
        .push      (pk_push),
        .data      (rx_data),
        .word_full (pk_full),
        .word      (pk_word)
    );

    // State, word index, session length and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic plus the address mux and handshake/status outputs.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        err_d      = err_q;
        pk_clear   = 1'b0;
        pk_push    = 1'b0;
        rx_ready   = 1'b0;
        mem_we     = 1'b0;
        load_done  = 1'b0;
        core_stall = 1'b1;
        mem_a      = {{(32 - LEN_W - 2){1'b0}}, word_idx_q, 2'b00};

        case (state_q)
            IDLE: begin
                core_stall = 1'b0;
                mem_a      = fetch_a;
                if (load_start) begin
                    if (load_len > WORDS_L) begin
                        err_d = 1'b1;
                    end else if (load_len == '0) begin
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        word_idx_d = '0;
                        len_d      = load_len;
                        err_d      = 1'b0;
                        pk_clear   = 1'b1;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                rx_ready = 1'b1;
                pk_push  = rx_valid;
                if (pk_full) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_we     = 1'b1;
                word_idx_d = word_idx_q + 1'b1;
                state_d    = (word_idx_d == len_q) ? DONE : LOAD;
            end
            DONE: begin
                load_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load_busy = core_stall;
    assign load_err  = err_q;
    assign mem_wd    = pk_word;

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - directed scoreboard bench for imem_ctrl
module tb_imem_ctrl;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [15:0] load_len;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [31:0] fetch_a;
    logic        core_stall;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  src[$];
    logic [31:0] mem_model [0:255];
    int          tests = 0;
    int          fails = 0;
    int          dc;

    imem_ctrl #(.BYTES(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .fetch_a    (fetch_a),
        .core_stall (core_stall),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Memory model: what the instruction memory would hold.
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem_model[mem_a[9:2]] <= mem_wd;
    end

    // Scoreboard: every memory write must match the next expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", mem_a, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", mem_a, w.a);
                check("write_data", mem_wd, w.d);
            end
        end
    end

    // Runs one load session; returns cycles from load_start to load_done, -1 on timeout.
    task automatic session(input logic [15:0] len, input int nbytes, input int gap_at,
                           input int gap_cycles, input int restart_at, output int done_cyc);
        int  n;
        int  idx;
        int  gap_left;
        logic hs;
        idx      = 0;
        gap_left = gap_cycles;
        done_cyc = -1;
        load_start = 1'b1;
        load_len   = len;
        rx_valid   = 1'b0;
        tick();
        n = 1;
        load_start = 1'b0;
        while (n < 400) begin
            if (load_done === 1'b1) begin
                done_cyc = n;
                break;
            end
            load_start = (n == restart_at);
            if (n == restart_at) load_len = 16'd5;
            if (idx < nbytes && !(idx == gap_at && gap_left > 0)) begin
                rx_valid = 1'b1;
                rx_data  = src[idx];
            end else begin
                rx_valid = 1'b0;
                if (idx == gap_at && gap_left > 0) gap_left--;
            end
            hs = rx_valid && rx_ready;
            tick();
            n++;
            if (hs) idx++;
        end
        rx_valid   = 1'b0;
        load_start = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        load_len   = 16'd0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        fetch_a    = 32'h0000_0000;
        tick();
        tick();

        check("rst_rx_ready",  {31'd0, rx_ready},   32'd0);
        check("rst_stall",     {31'd0, core_stall}, 32'd0);
        check("rst_busy",      {31'd0, load_busy},  32'd0);
        check("rst_done",      {31'd0, load_done},  32'd0);
        check("rst_err",       {31'd0, load_err},   32'd0);
        check("rst_we",        {31'd0, mem_we},     32'd0);
        check("rst_wd",        mem_wd,              32'd0);
        rst = 1'b0;
        tick();

        // Run mode: combinational fetch pass-through
        fetch_a = 32'h0000_0010;
        #1;
        check("run_mem_a",  mem_a,               32'h0000_0010);
        check("run_we",     {31'd0, mem_we},     32'd0);
        check("run_stall",  {31'd0, core_stall}, 32'd0);
        fetch_a = 32'h0000_03FC;
        #1;
        check("run_mem_a2", mem_a,               32'h0000_03FC);
        tick();

        // Two-word continuous load
        src = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        push_exp(32'h0, 32'h1234_5678);
        push_exp(32'h4, 32'hDEAD_BEEF);
        session(16'd2, 8, -1, 0, -1, dc);
        check("two_word_done_cyc", dc, 32'd11);
        check("two_word_stall_at_done", {31'd0, core_stall}, 32'd1);
        tick();
        check("two_word_stall_after", {31'd0, core_stall}, 32'd0);
        check("two_word_busy_after",  {31'd0, load_busy},  32'd0);
        check("two_word_mem1", mem_model[1], 32'hDEAD_BEEF);

        // Gapped stream: 3 idle cycles between bytes 2 and 3
        push_exp(32'h0, 32'h1234_5678);
        push_exp(32'h4, 32'hDEAD_BEEF);
        session(16'd2, 8, 2, 3, -1, dc);
        check("gap_done_cyc", dc, 32'd14);
        tick();

        // Overflow rejected, error sticky
        load_start = 1'b1;
        load_len   = 16'd257;
        tick();
        load_start = 1'b0;
        check("ovf_err",   {31'd0, load_err},   32'd1);
        check("ovf_stall", {31'd0, core_stall}, 32'd0);
        check("ovf_mem_a", mem_a,               32'h0000_03FC);
        tick();
        tick();
        check("ovf_err_sticky", {31'd0, load_err}, 32'd1);

        // Following 1-word load clears the error
        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_exp(32'h0, 32'h0403_0201);
        session(16'd1, 4, -1, 0, -1, dc);
        check("clr_done_cyc", dc, 32'd6);
        check("clr_err", {31'd0, load_err}, 32'd0);
        tick();

        // Zero length: immediate done, no writes
        load_start = 1'b1;
        load_len   = 16'd0;
        tick();
        load_start = 1'b0;
        check("zero_done", {31'd0, load_done}, 32'd1);
        tick();
        check("zero_done_pulse", {31'd0, load_done},  32'd0);
        check("zero_stall",      {31'd0, core_stall}, 32'd0);

        // Ignored start during LOAD: still a single write at address 0
        src = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        push_exp(32'h0, 32'hCAFE_F00D);
        session(16'd1, 4, -1, 0, 2, dc);
        check("ign_done_cyc", dc, 32'd6);
        tick();
        tick();
        check("ign_idle", {31'd0, core_stall}, 32'd0);

        // Exactly WORDS is accepted
        load_start = 1'b1;
        load_len   = 16'd256;
        tick();
        load_start = 1'b0;
        check("max_len_err",  {31'd0, load_err},  32'd0);
        check("max_len_busy", {31'd0, load_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("max_len_rst_busy", {31'd0, load_busy}, 32'd0);

        // Reset mid-word: word 0 written, word 1 partial then reset
        src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        push_exp(32'h0, 32'h4433_2211);
        begin
            int   idx;
            logic hs;
            idx = 0;
            load_start = 1'b1;
            load_len   = 16'd2;
            tick();
            load_start = 1'b0;
            repeat (7) begin
                rx_valid = 1'b1;
                rx_data  = src[idx];
                hs = rx_ready;
                tick();
                if (hs) idx++;
            end
        end
        rst      = 1'b1;
        rx_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_rst_rx_ready", {31'd0, rx_ready},   32'd0);
        check("mid_rst_stall",    {31'd0, core_stall}, 32'd0);
        check("mid_rst_busy",     {31'd0, load_busy},  32'd0);
        check("mid_rst_err",      {31'd0, load_err},   32'd0);
        check("mid_rst_we",       {31'd0, mem_we},     32'd0);
        check("mid_rst_wd",       mem_wd,              32'd0);
        check("mid_rst_mem_a",    mem_a,               32'h0000_03FC);
        check("mid_rst_word0",    mem_model[0],        32'h4433_2211);
        repeat (5) tick();
        check("sb_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
